ft245_sff_responder: RTL and testbench

- Device-side (FT245 chip side) responder for the FT245 synchronous FIFO interface that the housekeeper front end drives as initiator.
- Sits opposite the FPGA core in simulation and loopback/self-test builds:
  - buffers host→FPGA bytes into an RX FIFO and serves them on RXFn/RDn/OEn;
  - accepts FPGA→host bytes on TXEn/WRn into a TX FIFO and streams them out to a host-side port.
- Flags initiator protocol violations.

---
 rtl/ft245_pkg.sv | 15 +
 rtl/sync_fifo_fwft.sv | 69 ++++++
 rtl/ft245_sff_responder.sv | 100 ++++++++++
 tb/tb_ft245_sff_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ft245_pkg
// Purpose  : Shared types and constants for the FT245 sync-FIFO responder.
// Revision : 1.0 - initial release
// ============================================================================
package ft245_pkg;

    typedef logic [7:0] byte_t;

    localparam int   DEFAULT_DEPTH = 16;
    localparam logic ACTIVE_LOW    = 1'b0;

endpackage : ft245_pkg
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Purpose  : Single-clock first-word-fall-through FIFO with occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL_LVL  = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [AW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [AW:0]      r_level_q,  w_level_d;
    logic             w_do_wr, w_do_rd;

    assign full    = (r_level_q == C_FULL_LVL);
    assign empty   = (r_level_q == '0);
    assign level   = r_level_q;
    assign rd_data = r_mem_q[r_rd_ptr_q];

    // Requests are self-gated so a caller can never overrun or underrun.
    always_comb begin
        w_do_wr    = wr_en & ~full;
        w_do_rd    = rd_en & ~empty;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_do_wr) w_wr_ptr_d = r_wr_ptr_q + AW'(1);
        if (w_do_rd) w_rd_ptr_d = r_rd_ptr_q + AW'(1);
        case ({w_do_wr, w_do_rd})
            2'b10:   w_level_d = r_level_q + (AW+1)'(1);
            2'b01:   w_level_d = r_level_q - (AW+1)'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem_q[r_wr_ptr_q] <= wr_data;
    end

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/ft245_sff_responder.sv
`default_nettype none
// ============================================================================
// Module   : ft245_sff_responder
// Purpose  : FT245 sync-FIFO device-side responder with RX/TX buffering and
//            sticky initiator protocol-violation detection.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_sff_responder
    import ft245_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        ARst,
    input  logic        HRxValid,
    input  logic [7:0]  HRxData,
    output logic        HRxReady,
    output logic        HTxValid,
    output logic [7:0]  HTxData,
    input  logic        HTxReady,
    output logic        RXFn,
    output logic        TXEn,
    input  logic        RDn,
    input  logic        WRn,
    input  logic        OEn,
    output logic [7:0]  DOut,
    output logic        DOe,
    input  logic [7:0]  DIn,
    output logic [AW:0] RxLevel,
    output logic [AW:0] TxLevel,
    output logic        ProtoErr
);

    logic  r_in_rst_q;
    logic  r_proto_err_q, w_proto_err_d;
    logic  w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic  w_rd_req, w_wr_req;
    logic  w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    byte_t w_rx_head, w_tx_head;

    // Flags are forced inactive from a registered copy of reset so that no
    // input reaches an output combinationally (DOe excepted).
    assign RXFn     = w_rx_empty | r_in_rst_q;
    assign TXEn     = w_tx_full  | r_in_rst_q;
    assign HRxReady = ~w_rx_full  & ~r_in_rst_q;
    assign HTxValid = ~w_tx_empty & ~r_in_rst_q;
    assign DOut     = w_rx_head;
    assign HTxData  = w_tx_head;
    assign DOe      = ~OEn;
    assign ProtoErr = r_proto_err_q;

    always_comb begin
        w_rd_req  = (RDn == ACTIVE_LOW);
        w_wr_req  = (WRn == ACTIVE_LOW);
        w_rx_push = HRxValid & HRxReady;
        w_tx_pop  = HTxValid & HTxReady;
        w_rx_pop  = w_rd_req & ~w_wr_req & ~RXFn;
        w_tx_push = w_wr_req & ~w_rd_req & ~TXEn;

        w_proto_err_d = r_proto_err_q;
        if ((w_rd_req & w_wr_req) |
            (w_rd_req & RXFn)     |
            (w_wr_req & TXEn)     |
            (w_rx_pop & OEn))
            w_proto_err_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        r_in_rst_q <= ARst;
        if (ARst) r_proto_err_q <= 1'b0;
        else      r_proto_err_q <= w_proto_err_d;
    end

    sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (Clk),
        .rst     (ARst),
        .wr_en   (w_rx_push),
        .wr_data (HRxData),
        .rd_en   (w_rx_pop),
        .rd_data (w_rx_head),
        .level   (RxLevel),
        .full    (w_rx_full),
        .empty   (w_rx_empty)
    );

    sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (Clk),
        .rst     (ARst),
        .wr_en   (w_tx_push),
        .wr_data (DIn),
        .rd_en   (w_tx_pop),
        .rd_data (w_tx_head),
        .level   (TxLevel),
        .full    (w_tx_full),
        .empty   (w_tx_empty)
    );

endmodule : ft245_sff_responder
`default_nettype wire

// File: tb/tb_ft245_sff_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_sff_responder
// Purpose  : Directed self-checking bench with byte scoreboards for RX and TX.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft245_sff_responder;

    localparam int DEPTH = 16;

    logic       Clk = 1'b0;
    logic       ARst, HRxValid, HTxReady, RDn, WRn, OEn;
    logic [7:0] HRxData, DIn;
    logic       HRxReady, HTxValid, RXFn, TXEn, DOe, ProtoErr;
    logic [7:0] HTxData, DOut;
    logic [4:0] RxLevel, TxLevel;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         rx_lvl = 0;
    int         tx_lvl = 0;
    logic       exp_perr = 1'b0;

    always #5 Clk = ~Clk;

    ft245_sff_responder #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .ARst(ARst),
        .HRxValid(HRxValid), .HRxData(HRxData), .HRxReady(HRxReady),
        .HTxValid(HTxValid), .HTxData(HTxData), .HTxReady(HTxReady),
        .RXFn(RXFn), .TXEn(TXEn), .RDn(RDn), .WRn(WRn), .OEn(OEn),
        .DOut(DOut), .DOe(DOe), .DIn(DIn),
        .RxLevel(RxLevel), .TxLevel(TxLevel), .ProtoErr(ProtoErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        HRxValid = 1'b0; HTxReady = 1'b0;
        RDn = 1'b1; WRn = 1'b1; OEn = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        ARst = 1'b1;
        tick();
        ARst = 1'b0;
        tick();
        rx_q.delete(); tx_q.delete();
        rx_lvl = 0; tx_lvl = 0; exp_perr = 1'b0;
    endtask

    task automatic host_push(input logic [7:0] b);
        HRxValid = 1'b1; HRxData = b;
        if (rx_lvl < DEPTH) begin
            rx_q.push_back(b);
            rx_lvl++;
        end
        tick();
        HRxValid = 1'b0;
    endtask

    task automatic fpga_read();
        logic [7:0] e;
        OEn = 1'b0; RDn = 1'b0;
        if (rx_q.size() == 0) begin
            chk("read_sb_empty", 32'(rx_q.size()), 32'd1);
        end else begin
            e = rx_q.pop_front();
            rx_lvl--;
            chk("dout", 32'(DOut), 32'(e));
        end
        tick();
        RDn = 1'b1;
    endtask

    task automatic fpga_write(input logic [7:0] b);
        WRn = 1'b0; DIn = b;
        if (tx_lvl < DEPTH) begin
            tx_q.push_back(b);
            tx_lvl++;
        end else begin
            exp_perr = 1'b1;
        end
        tick();
        WRn = 1'b1;
    endtask

    task automatic host_drain(input int n);
        logic [7:0] e;
        HTxReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = tx_q.pop_front();
            tx_lvl--;
            chk("htx_valid", 32'(HTxValid), 32'd1);
            chk("htx_data", 32'(HTxData), 32'(e));
            tick();
        end
        HTxReady = 1'b0;
    endtask

    initial begin
        HRxData = 8'h00; DIn = 8'h00;
        idle();

        // Reset with random strobes
        ARst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            RDn = 1'($urandom); WRn = 1'($urandom); OEn = 1'($urandom);
            HRxValid = 1'($urandom); HTxReady = 1'($urandom);
            HRxData = 8'($urandom); DIn = 8'($urandom);
            tick();
            chk("rst_rxfn", 32'(RXFn), 32'd1);
            chk("rst_txen", 32'(TXEn), 32'd1);
            chk("rst_hrxready", 32'(HRxReady), 32'd0);
            chk("rst_htxvalid", 32'(HTxValid), 32'd0);
            chk("rst_protoerr", 32'(ProtoErr), 32'd0);
            chk("rst_rxlevel", 32'(RxLevel), 32'd0);
            chk("rst_txlevel", 32'(TxLevel), 32'd0);
        end
        idle();
        ARst = 1'b0;
        tick();
        chk("rel_txen", 32'(TXEn), 32'd0);
        chk("rel_hrxready", 32'(HRxReady), 32'd1);
        chk("rel_rxfn", 32'(RXFn), 32'd1);

        // Read path
        host_push(8'hA5);
        chk("rd_rxfn_fall", 32'(RXFn), 32'd0);
        chk("rd_dout_first", 32'(DOut), 32'hA5);
        host_push(8'h3C);
        OEn = 1'b0;
        #1;
        chk("rd_doe_on", 32'(DOe), 32'd1);
        fpga_read();
        fpga_read();
        chk("rd_rxfn_rise", 32'(RXFn), 32'd1);
        chk("rd_protoerr", 32'(ProtoErr), 32'd0);
        OEn = 1'b1;
        #1;
        chk("rd_doe_off", 32'(DOe), 32'd0);

        // RX full
        for (int i = 0; i <= DEPTH; i++) begin
            host_push(8'(i));
            chk("rxfull_hrxready", 32'(HRxReady), (i >= DEPTH - 1) ? 32'd0 : 32'd1);
        end
        chk("rxfull_level", 32'(RxLevel), 32'd16);
        for (int i = 0; i < DEPTH; i++) fpga_read();
        chk("rxfull_drained", 32'(RXFn), 32'd1);
        chk("rxfull_protoerr", 32'(ProtoErr), 32'd0);

        // TX path
        for (int i = 0; i <= DEPTH; i++) begin
            fpga_write(8'(8'h11 + i));
            if (i == DEPTH - 1) begin
                chk("tx_txen_full", 32'(TXEn), 32'd1);
                chk("tx_perr_before", 32'(ProtoErr), 32'd0);
            end
        end
        chk("tx_overrun_perr", 32'(ProtoErr), 32'(exp_perr));
        chk("tx_level", 32'(TxLevel), 32'd16);
        host_drain(DEPTH);
        chk("tx_drained", 32'(HTxValid), 32'd0);

        // Bus conflict
        do_reset();
        chk("perr_cleared", 32'(ProtoErr), 32'd0);
        host_push(8'h01);
        host_push(8'h02);
        fpga_write(8'h77);
        RDn = 1'b0; WRn = 1'b0; OEn = 1'b0;
        tick();
        idle();
        chk("conf_rxlevel", 32'(RxLevel), 32'd2);
        chk("conf_txlevel", 32'(TxLevel), 32'd1);
        chk("conf_perr", 32'(ProtoErr), 32'd1);

        // Read underrun
        do_reset();
        RDn = 1'b0; OEn = 1'b0;
        tick();
        idle();
        chk("under_rxlevel", 32'(RxLevel), 32'd0);
        chk("under_perr", 32'(ProtoErr), 32'd1);

        // Pop without output enable still pops but flags an error
        do_reset();
        host_push(8'hC3);
        RDn = 1'b0; OEn = 1'b1;
        tick();
        idle();
        chk("noe_rxlevel", 32'(RxLevel), 32'd0);
        chk("noe_perr", 32'(ProtoErr), 32'd1);

        // Reset during active read
        do_reset();
        for (int i = 0; i < 5; i++) host_push(8'(8'h40 + i));
        for (int i = 0; i < 3; i++) fpga_write(8'(8'h60 + i));
        chk("mid_rxlevel_pre", 32'(RxLevel), 32'd5);
        chk("mid_txlevel_pre", 32'(TxLevel), 32'd3);
        RDn = 1'b0; OEn = 1'b0; ARst = 1'b1;
        tick();
        ARst = 1'b0; idle();
        rx_q.delete(); tx_q.delete(); rx_lvl = 0; tx_lvl = 0;
        chk("mid_rxlevel", 32'(RxLevel), 32'd0);
        chk("mid_txlevel", 32'(TxLevel), 32'd0);
        chk("mid_rxfn", 32'(RXFn), 32'd1);
        chk("mid_htxvalid", 32'(HTxValid), 32'd0);
        tick();
        host_push(8'h5A);
        fpga_read();
        chk("mid_empty_after", 32'(RXFn), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ft245_sff_responder
`default_nettype wire
